// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V controller.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Formats without an immediate (R-type) fall back to I; the value is unused there.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] sel;
        case (op)
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_JAL:    sel = IMM_J;
            OP_LUI:    sel = IMM_U;
            default:   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/riscv_mc_controller_alu_decoder.sv
// ALU operation decode for R-type and I-type arithmetic; purely combinational.
module riscv_alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] alu_control
);

    logic unused_f7;
    assign unused_f7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alu_control = ALU_ADD;
        if (op == OP_R || op == OP_I) begin
            case (funct3)
                3'b000:  alu_control = (op == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b100:  alu_control = ALU_XOR;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: alu_control = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RISC-V control FSM with parametrised memory wait and sticky illegal-opcode trap.
// Performance counters exist only when RISCV_MC_PERF_EN is defined.
module riscv_mc_controller
    import riscv_mc_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             alu_res_sign,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [2:0]       imm_src,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_retired
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          last, mem_state, take;
    logic          illegal_q;
    logic          pcw, memw, irw, regw;
    logic [2:0]    alu_dec;

    riscv_alu_decoder u_alu_dec (
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (alu_dec)
    );

    assign mem_state = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign last      = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (mem_state && !last)
                cnt <= cnt + 1'b1;
            illegal_q <= illegal_q | (state_n == S_TRAP);
        end
    end

    // Overflow is deliberately ignored: sign alone decides blt/bge.
    always_comb begin
        case (funct3)
            3'b000:  take = zero;
            3'b001:  take = ~zero;
            3'b100:  take = alu_res_sign;
            3'b101:  take = ~alu_res_sign;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_n     = state;
        pcw         = 1'b0;
        adr_src     = 1'b0;
        memw        = 1'b0;
        irw         = 1'b0;
        regw        = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_B;
        alu_control = ALU_ADD;
        imm_src     = imm_sel(op);
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                if (last) begin
                    irw     = 1'b1;
                    pcw     = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_n = S_MEM_ADR;
                    OP_R:              state_n = S_EXEC_R;
                    OP_I:              state_n = S_EXEC_I;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR;
                    OP_LUI:            state_n = S_LUI;
                    default:           state_n = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                state_n   = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                adr_src = 1'b1;
                if (last) state_n = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = RES_DATA;
                regw       = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEM_WR: begin
                adr_src = 1'b1;
                memw    = 1'b1;
                if (last) state_n = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a   = SRCA_A;
                alu_control = alu_dec;
                state_n     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a   = SRCA_A;
                alu_src_b   = SRCB_IMM;
                alu_control = alu_dec;
                state_n     = S_ALU_WB;
            end
            S_ALU_WB: begin
                regw    = 1'b1;
                state_n = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRCA_A;
                alu_control = ALU_SUB;
                pcw         = take;
                state_n     = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                state_n   = S_JAL;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pcw       = 1'b1;
                state_n   = S_ALU_WB;
            end
            S_LUI: begin
                result_src = RES_IMM;
                regw       = 1'b1;
                state_n    = S_FETCH;
            end
            S_TRAP:  state_n = S_TRAP;
            default: state_n = S_FETCH;
        endcase
    end

    assign pc_write  = pcw  & ~rst;
    assign mem_write = memw & ~rst;
    assign ir_write  = irw  & ~rst;
    assign reg_write = regw & ~rst;
    assign illegal   = illegal_q;

`ifdef RISCV_MC_PERF_EN
    logic [CNT_W-1:0] cyc_q, ret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (state_n == S_FETCH && state != S_FETCH)
                ret_q <= ret_q + 1'b1;
        end
    end

    assign cycle_count   = cyc_q;
    assign instr_retired = ret_q;
`else
    assign cycle_count   = '0;
    assign instr_retired = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench: one zero-wait instance (dut1) and one 3-cycle-memory instance (dut3).
module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0, alu_res_sign = 1'b0;

    logic        pcw1, adr1, mw1, irw1, rw1, ill1;
    logic [1:0]  rs1, sa1, sb1;
    logic [2:0]  alu1, imm1;
    logic [31:0] cyc1, ret1;
    logic        pcw3, adr3, mw3, irw3, rw3, ill3;
    logic [1:0]  rs3, sa3, sb3;
    logic [2:0]  alu3, imm3;
    logic [31:0] cyc3, ret3;

    always #5 clk = ~clk;

    riscv_mc_controller #(.MEM_LATENCY(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
        .alu_res_sign(alu_res_sign), .pc_write(pcw1), .adr_src(adr1), .mem_write(mw1),
        .ir_write(irw1), .reg_write(rw1), .result_src(rs1), .alu_src_a(sa1),
        .alu_src_b(sb1), .alu_control(alu1), .imm_src(imm1), .illegal(ill1),
        .cycle_count(cyc1), .instr_retired(ret1)
    );

    riscv_mc_controller #(.MEM_LATENCY(3), .CNT_W(32)) dut3 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
        .alu_res_sign(alu_res_sign), .pc_write(pcw3), .adr_src(adr3), .mem_write(mw3),
        .ir_write(irw3), .reg_write(rw3), .result_src(rs3), .alu_src_a(sa3),
        .alu_src_b(sb3), .alu_control(alu3), .imm_src(imm3), .illegal(ill3),
        .cycle_count(cyc3), .instr_retired(ret3)
    );

    logic [17:0] obs1, obs3;
    assign obs1 = {pcw1, adr1, mw1, irw1, rw1, rs1, sa1, sb1, alu1, imm1, ill1};
    assign obs3 = {pcw3, adr3, mw3, irw3, rw3, rs3, sa3, sb3, alu3, imm3, ill3};

    typedef struct {
        bit          sel;
        logic [17:0] v;
        bit          pchk;
        logic [31:0] cyc;
        logic [31:0] ret;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Vector layout: pc_write adr_src mem_write ir_write reg_write result_src a b alu imm illegal
    function automatic logic [17:0] ev(input logic pw, ad, mw, iw, rw, input logic [1:0] rs,
                                       input logic [1:0] a, b, input logic [2:0] alu, imm,
                                       input logic il);
        return {pw, ad, mw, iw, rw, rs, a, b, alu, imm, il};
    endfunction

    function automatic logic [17:0] f_fetch(input logic [2:0] imm, input logic fin);
        return ev(fin, 0, 0, fin, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
    endfunction

    function automatic logic [17:0] f_dec(input logic [2:0] imm);
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
    endfunction

    task automatic push(input bit sel, input string nm, input logic [17:0] v,
                        input bit pchk, input logic [31:0] c, input logic [31:0] r);
        exp_t e;
        e.sel = sel; e.v = v; e.pchk = pchk; e.cyc = c; e.ret = r; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic cyc(input bit sel, input string nm, input logic [17:0] v);
        push(sel, nm, v, 1'b0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Raise reset mid-cycle, expect the reset view at the next falling edge, release before the rising edge.
    task automatic rst_mid(input bit sel, input string nm);
        rst = 1'b1;
        push(sel, nm, ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0), 1'b0, 0, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic s);
        op = o; funct3 = f3; funct7 = f7; zero = z; alu_res_sign = s;
    endtask

    initial begin
        exp_t        e;
        logic [17:0] act;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = e.sel ? obs3 : obs1;
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.v);
                end
                if (e.pchk) begin
                    checks++;
                    if (cyc1 !== e.cyc || ret1 !== e.ret) begin
                        errors++;
                        $display("FAIL %s_counters: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                                 e.name, cyc1, ret1, e.cyc, e.ret);
                    end
                end
            end
        end
    end

    logic [2:0] bf3 [6] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b100, 3'b101};
    bit         bz  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit         bs  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit         bt  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [31:0] exp_cyc, exp_ret;
`ifdef RISCV_MC_PERF_EN
        exp_cyc = 32'd12; exp_ret = 32'd3;
`else
        exp_cyc = 32'd0;  exp_ret = 32'd0;
`endif
        @(posedge clk); #1;

        // Three back-to-back adds on the zero-wait instance, then the counters.
        set_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(0, "add_fetch", f_fetch(3'b000, 1));
            cyc(0, "add_decode", f_dec(3'b000));
            cyc(0, "add_exec_r", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0));
            cyc(0, "add_alu_wb", ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        end
        push(0, "perf_fetch", f_fetch(3'b000, 1), 1'b1, exp_cyc, exp_ret);
        @(posedge clk); #1;

        set_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0);
        do_reset();
        cyc(0, "sub_fetch", f_fetch(3'b000, 1));
        cyc(0, "sub_decode", f_dec(3'b000));
        cyc(0, "sub_exec_r", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        cyc(0, "sub_alu_wb", ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));

        set_instr(7'b0010011, 3'b100, 7'b0100000, 0, 0);
        cyc(0, "xori_fetch", f_fetch(3'b000, 1));
        cyc(0, "xori_decode", f_dec(3'b000));
        cyc(0, "xori_exec_i", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b100, 3'b000, 0));
        cyc(0, "xori_alu_wb", ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));

        // lw and sw on the 3-cycle-memory instance.
        set_instr(7'b0000011, 3'b010, 7'b0000000, 0, 0);
        do_reset();
        cyc(1, "lw_fetch0", f_fetch(3'b000, 0));
        cyc(1, "lw_fetch1", f_fetch(3'b000, 0));
        cyc(1, "lw_fetch2", f_fetch(3'b000, 1));
        cyc(1, "lw_decode", f_dec(3'b000));
        cyc(1, "lw_mem_adr", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        for (int i = 0; i < 3; i++)
            cyc(1, "lw_mem_rd", ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        cyc(1, "lw_mem_wb", ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));

        set_instr(7'b0100011, 3'b010, 7'b0000000, 0, 0);
        cyc(1, "sw_fetch0", f_fetch(3'b001, 0));
        cyc(1, "sw_fetch1", f_fetch(3'b001, 0));
        cyc(1, "sw_fetch2", f_fetch(3'b001, 1));
        cyc(1, "sw_decode", f_dec(3'b001));
        cyc(1, "sw_mem_adr", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
        for (int i = 0; i < 3; i++)
            cyc(1, "sw_mem_wr", ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
        cyc(1, "sw_next_fetch", f_fetch(3'b001, 0));

        // Branch condition table on the zero-wait instance.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_instr(7'b1100011, bf3[i], 7'b0000000, bz[i], bs[i]);
            cyc(0, "br_fetch", f_fetch(3'b010, 1));
            cyc(0, "br_decode", f_dec(3'b010));
            cyc(0, "br_branch", ev(bt[i], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));
        end

        set_instr(7'b1100111, 3'b000, 7'b0000000, 0, 0);
        cyc(0, "jalr_fetch", f_fetch(3'b000, 1));
        cyc(0, "jalr_decode", f_dec(3'b000));
        cyc(0, "jalr_jalr", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        cyc(0, "jalr_jal", ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0));
        cyc(0, "jalr_alu_wb", ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));

        set_instr(7'b1101111, 3'b000, 7'b0000000, 0, 0);
        cyc(0, "jal_fetch", f_fetch(3'b011, 1));
        cyc(0, "jal_decode", f_dec(3'b011));
        cyc(0, "jal_jal", ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0));
        cyc(0, "jal_alu_wb", ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 0));

        set_instr(7'b0110111, 3'b000, 7'b0000000, 0, 0);
        cyc(0, "lui_fetch", f_fetch(3'b100, 1));
        cyc(0, "lui_decode", f_dec(3'b100));
        cyc(0, "lui_lui", ev(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 0));

        // Illegal opcode trap and asynchronous reset recovery on the 3-cycle instance.
        set_instr(7'b1111111, 3'b000, 7'b0000000, 0, 0);
        do_reset();
        cyc(1, "ill_fetch0", f_fetch(3'b000, 0));
        cyc(1, "ill_fetch1", f_fetch(3'b000, 0));
        cyc(1, "ill_fetch2", f_fetch(3'b000, 1));
        cyc(1, "ill_decode", f_dec(3'b000));
        for (int i = 0; i < 3; i++)
            cyc(1, "ill_trap", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1));
        rst_mid(1, "rst_from_trap");
        cyc(1, "post_rst_fetch1", f_fetch(3'b000, 0));
        rst_mid(1, "rst_mid_fetch");
        cyc(1, "rerun_fetch1", f_fetch(3'b000, 0));
        cyc(1, "rerun_fetch2", f_fetch(3'b000, 1));
        cyc(1, "rerun_decode", f_dec(3'b000));
        cyc(1, "rerun_trap", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1));

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
- Multi-cycle RISC-V control unit; successor to the single-cycle controller.
- Drives a shared-memory multi-cycle datapath (PC, OldPC, IR, A/B, ALUOut, Data registers) from an FSM.
- Memory latency is parametrised, so one design serves zero-wait and slow unified memories.
- Flags illegal opcodes and holds in a trap state.

Parameters:
- MEM_LATENCY, 1, cycles each memory state (FETCH, MEM_RD, MEM_WR) occupies; must be ≥1.
- CNT_W, 32, width of the performance counters (optional feature).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU result == 0
- alu_res_sign  in  1  ALU result bit 31
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR and OldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult, 11 Imm
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 A
- alu_src_b  out  2  ALU B select: 00 B, 01 Imm, 10 const 4
- alu_control  out  3  ALU operation (package encoding)
- imm_src  out  3  immediate format: I=000, S=001, B=010, J=011, U=100
- illegal  out  1  sticky illegal-opcode flag
- cycle_count  out  CNT_W  cycles since reset
- instr_retired  out  CNT_W  completed instructions

Behaviour:
- Reset is asynchronous and active-high. It sets state=FETCH, clears the wait counter, illegal and both counters.
- All strobes are deasserted while rst is high. Reset mid-wait abandons the access.
- Outputs are a Moore decode of the state, plus the final-cycle qualifier and the branch condition. Unlisted strobes are 0.
- Memory wait:
  - Counter width is $clog2(MEM_LATENCY+1). It counts within FETCH, MEM_RD and MEM_WR.
  - The final cycle is count == MEM_LATENCY-1.
  - Only in the final cycle do the FSM advance and the pc_write / ir_write / reg-side updates occur.
  - mem_write stays high for every cycle of MEM_WR. The counter clears on any state change.
- FETCH: adr_src=0, a=00, b=10, ADD, result_src=10; ir_write=1 and pc_write=1 in the final cycle. Next: DECODE.
- DECODE: a=01, b=01, ADD (ALUOut = OldPC+imm). imm_src follows op. Next state by op:
  - 0000011 / 0100011 → MEM_ADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - else → TRAP
- MEM_ADR: a=10, b=01, ADD. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: adr_src=1. Final cycle → MEM_WB.
- MEM_WB: result_src=01, reg_write=1. Next: FETCH.
- MEM_WR: adr_src=1, mem_write=1. Final cycle → FETCH.
- EXEC_R: a=10, b=00, alu_control from the sub-decoder. Next: ALU_WB.
- EXEC_I: a=10, b=01, alu_control from the sub-decoder. Next: ALU_WB.
- ALU_WB: result_src=00, reg_write=1. Next: FETCH.
- BRANCH: a=10, b=00, SUB, result_src=00.
  - pc_write = (f3=000 & zero) | (f3=001 & ~zero) | (f3=100 & sign) | (f3=101 & ~sign).
  - Signed overflow is ignored by design. Next: FETCH.
- JALR: a=10, b=01, ADD (ALUOut = rs1+imm). Next: JAL.
- JAL: a=01, b=10, ADD, result_src=00, pc_write=1 (PC = target, ALUOut = OldPC+4). Next: ALU_WB.
- LUI: result_src=11, reg_write=1. Next: FETCH.
- TRAP: illegal=1, no strobes, no exit except rst.
- ALU decode:
  - Encodings: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101.
  - R-type: f3=000 gives SUB when funct7[5]=1, else ADD.
  - I-type: funct7 is ignored; unsupported f3 maps to ADD.

Optional Feature:
- Macro RISCV_MC_PERF_EN.
- Defined:
  - cycle_count increments every cycle out of reset.
  - instr_retired increments on every transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^CNT_W.
- Undefined: both outputs are constant 0 and no counter flops are inferred.

Decomposition:
- Package riscv_mc_pkg holds:
  - state enum;
  - opcode constants;
  - ALU_* and IMM_* encodings;
  - result / src-A / src-B select constants.
- One natural combinational sub-module: riscv_alu_decoder (op, funct3, funct7 → alu_control).

Test Plan:
- add x3,x1,x2, MEM_LATENCY=1 → FETCH, DECODE, EXEC_R, ALU_WB; 4 cycles; reg_write only in cycle 4 with alu_control=000.
- lw with MEM_LATENCY=3 → FETCH 3 cycles with ir_write only in cycle 3; MEM_RD 3 cycles; 9 cycles total; reg_write with result_src=01.
- bne with zero=0, then zero=1 → pc_write=1 in BRANCH, then 0; alu_control=001 both times.
- jalr → JALR, JAL, ALU_WB sequence; pc_write=1 in JAL; reg_write with result_src=00.
- op=1111111 → illegal=1 after DECODE and stays there. rst pulse mid-FETCH-wait → state FETCH, counter 0, illegal=0 immediately, asynchronously.
- With RISCV_MC_PERF_EN: 3 adds → instr_retired=3, cycle_count=12. Without it both read 0.
